// File: rtl/write_data_fifo.sv
// AXI W-channel beat buffer: first-word-fall-through FIFO holding data/strb/user/last,
// with pop strobe and a running count of complete bursts (WLAST beats) held.
module write_data_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STRB_W = 8,
  parameter int unsigned USER_W = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          s_WDATA,
  input  logic [STRB_W-1:0]          s_WSTRB,
  input  logic [USER_W-1:0]          s_WUSER,
  input  logic                       s_WLAST,
  input  logic                       s_WVALID,
  output logic                       s_WREADY,
  output logic [DATA_W-1:0]          m_WDATA,
  output logic [STRB_W-1:0]          m_WSTRB,
  output logic [USER_W-1:0]          m_WUSER,
  output logic                       m_WLAST,
  output logic                       m_WVALID,
  input  logic                       m_WREADY,
  output logic                       empty,
  output logic                       full,
  output logic                       r_enable,
  output logic                       burst_avail,
  output logic [$clog2(DEPTH):0]     burst_cnt
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = DATA_W + STRB_W + USER_W + 1;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [EntryW-1:0] head;
  logic              push, pop;
  logic              burst_inc, burst_dec;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  // Held low during reset even though count is already zero.
  assign s_WREADY = rst & ~full;
  assign m_WVALID = ~empty;
  assign push     = s_WVALID & s_WREADY;
  assign pop      = m_WVALID & m_WREADY;
  assign r_enable = pop;

  // FWFT head: memory read straight out, no output register and no bypass.
  assign head = mem_q[rd_ptr_q];
  assign {m_WDATA, m_WSTRB, m_WUSER, m_WLAST} = head;

  assign burst_inc   = push & s_WLAST;
  assign burst_dec   = pop & m_WLAST;
  assign burst_cnt   = burst_cnt_q;
  assign burst_avail = (burst_cnt_q != '0);

  // Next-state for storage, pointers and occupancy counters.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    burst_cnt_d = burst_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {s_WDATA, s_WSTRB, s_WUSER, s_WLAST};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case ({burst_inc, burst_dec})
      2'b10:   burst_cnt_d = burst_cnt_q + CntW'(1);
      2'b01:   burst_cnt_d = burst_cnt_q - CntW'(1);
      default: burst_cnt_d = burst_cnt_q;
    endcase
  end

  // Control state, cleared asynchronously; stored beats are dropped on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Beat storage is not reset; contents are only observed when non-empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_write_data_fifo.sv
// Bench for write_data_fifo: directed scenarios plus random traffic against a queue model.
module tb_write_data_fifo;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned USER_W = 6;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W  = DATA_W + STRB_W + USER_W + 1;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] s_WDATA;
  logic [STRB_W-1:0] s_WSTRB;
  logic [USER_W-1:0] s_WUSER;
  logic              s_WLAST;
  logic              s_WVALID;
  logic              s_WREADY;
  logic [DATA_W-1:0] m_WDATA;
  logic [STRB_W-1:0] m_WSTRB;
  logic [USER_W-1:0] m_WUSER;
  logic              m_WLAST;
  logic              m_WVALID;
  logic              m_WREADY;
  logic              empty;
  logic              full;
  logic              r_enable;
  logic              burst_avail;
  logic [CNT_W-1:0]  burst_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [ENT_W-1:0] model_q [$];
  logic [ENT_W-1:0] fill_e [DEPTH];

  write_data_fifo #(
    .DATA_W(DATA_W), .STRB_W(STRB_W), .USER_W(USER_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WUSER(s_WUSER), .s_WLAST(s_WLAST),
    .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WUSER(m_WUSER), .m_WLAST(m_WLAST),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .empty(empty), .full(full), .r_enable(r_enable),
    .burst_avail(burst_avail), .burst_cnt(burst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_bursts();
    int n = 0;
    foreach (model_q[i]) if (model_q[i][0]) n++;
    return n;
  endfunction

  function automatic logic [ENT_W-1:0] cur_beat();
    return {s_WDATA, s_WSTRB, s_WUSER, s_WLAST};
  endfunction

  task automatic set_beat(input logic last);
    s_WDATA = {$urandom(), $urandom()};
    s_WSTRB = STRB_W'($urandom());
    s_WUSER = USER_W'($urandom());
    s_WLAST = last;
  endtask

  // Advance one clock; the model applies the handshakes the inputs imply.
  task automatic tick();
    bit do_push, do_pop;
    logic [ENT_W-1:0] e;
    do_push = rst && s_WVALID && (model_q.size() < DEPTH);
    do_pop  = m_WREADY && (model_q.size() > 0);
    e = cur_beat();
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    s_WVALID = 1'b0;
    m_WREADY = 1'b1;
    for (int i = 0; i <= DEPTH; i++) if (model_q.size() > 0) tick();
    m_WREADY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_WVALID = 1'b1; m_WREADY = 1'b1; set_beat(1'b1);
    #1;
    total_cnt++; if (s_WREADY !== 1'b0) $display("FAIL reset_wready got=%b exp=0", s_WREADY); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else pass_cnt++;
    total_cnt++; if (m_WVALID !== 1'b0) $display("FAIL reset_mvalid got=%b exp=0", m_WVALID); else pass_cnt++;
    total_cnt++; if (burst_cnt !== '0) $display("FAIL reset_bcnt got=%0d exp=0", burst_cnt); else pass_cnt++;
    total_cnt++; if (r_enable !== 1'b0 || full !== 1'b0 || burst_avail !== 1'b0)
      $display("FAIL reset_flags got=%b%b%b exp=000", r_enable, full, burst_avail); else pass_cnt++;
    tick(); tick();
    s_WVALID = 1'b0; m_WREADY = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++; if (s_WREADY !== 1'b1) $display("FAIL release_wready got=%b exp=1", s_WREADY); else pass_cnt++;
    model_q.delete();
  endtask

  task automatic test_fill();
    m_WREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_beat(i == DEPTH - 1);
      fill_e[i] = cur_beat();
      s_WVALID = 1'b1;
      tick();
    end
    s_WVALID = 1'b0;
    #1;
    total_cnt++; if (full !== 1'b1) $display("FAIL fill_full got=%b exp=1", full); else pass_cnt++;
    total_cnt++; if (s_WREADY !== 1'b0) $display("FAIL fill_wready got=%b exp=0", s_WREADY); else pass_cnt++;
    total_cnt++; if (burst_cnt !== CNT_W'(1)) $display("FAIL fill_bcnt got=%0d exp=1", burst_cnt); else pass_cnt++;
    total_cnt++; if (m_WDATA !== fill_e[0][ENT_W-1 -: DATA_W])
      $display("FAIL fill_head got=%h exp=%h", m_WDATA, fill_e[0][ENT_W-1 -: DATA_W]); else pass_cnt++;
  endtask

  task automatic test_drain();
    m_WREADY = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total_cnt++; if (r_enable !== 1'b1) $display("FAIL drain_renable[%0d] got=%b exp=1", i, r_enable); else pass_cnt++;
      total_cnt++; if ({m_WDATA, m_WSTRB, m_WUSER, m_WLAST} !== fill_e[i])
        $display("FAIL drain_beat[%0d] got=%h exp=%h", i, {m_WDATA, m_WSTRB, m_WUSER, m_WLAST}, fill_e[i]);
      else pass_cnt++;
      total_cnt++; if (m_WLAST !== (i == DEPTH - 1)) $display("FAIL drain_last[%0d] got=%b", i, m_WLAST); else pass_cnt++;
      tick();
    end
    m_WREADY = 1'b0;
    #1;
    total_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else pass_cnt++;
    total_cnt++; if (burst_avail !== 1'b0) $display("FAIL drain_bavail got=%b exp=0", burst_avail); else pass_cnt++;
    total_cnt++; if (r_enable !== 1'b0) $display("FAIL drain_idle_renable got=%b exp=0", r_enable); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    m_WREADY = 1'b0; s_WVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin set_beat(1'b0); tick(); end
    m_WREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_beat(i == 0 ? 1'b1 : 1'(($urandom() & 1)));
      #1;
      total_cnt++; if (r_enable !== 1'b1 || s_WREADY !== 1'b1)
        $display("FAIL simul_hs[%0d] got=%b%b exp=11", i, r_enable, s_WREADY); else pass_cnt++;
      total_cnt++; if ({m_WDATA, m_WSTRB, m_WUSER, m_WLAST} !== model_q[0])
        $display("FAIL simul_head[%0d] got=%h exp=%h", i, {m_WDATA, m_WSTRB, m_WUSER, m_WLAST}, model_q[0]);
      else pass_cnt++;
      tick();
      #1;
      total_cnt++; if (model_q.size() != 2 || empty !== 1'b0 || full !== 1'b0)
        $display("FAIL simul_count[%0d] got e=%b f=%b exp occupancy 2", i, empty, full); else pass_cnt++;
      total_cnt++; if (burst_cnt !== CNT_W'(model_bursts()))
        $display("FAIL simul_bcnt[%0d] got=%0d exp=%0d", i, burst_cnt, model_bursts()); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (burst_cnt !== CNT_W'(1)) $display("FAIL simul_bcnt_inc got=%0d exp=1", burst_cnt); else pass_cnt++;
      end
    end
    drain();
  endtask

  task automatic test_full_pop();
    m_WREADY = 1'b0; s_WVALID = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin set_beat(1'(($urandom() & 1))); tick(); end
    set_beat(1'b1);
    m_WREADY = 1'b1;
    #1;
    total_cnt++; if (s_WREADY !== 1'b0 || r_enable !== 1'b1)
      $display("FAIL fullpop_hs got rdy=%b ren=%b exp rdy=0 ren=1", s_WREADY, r_enable); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (full !== 1'b0 || s_WREADY !== 1'b1)
      $display("FAIL fullpop_after got full=%b rdy=%b exp 0 1", full, s_WREADY); else pass_cnt++;
    m_WREADY = 1'b0;
    tick();
    #1;
    total_cnt++; if (full !== 1'b1) $display("FAIL fullpop_push got full=%b exp=1", full); else pass_cnt++;
    total_cnt++; if (burst_cnt !== CNT_W'(model_bursts()))
      $display("FAIL fullpop_bcnt got=%0d exp=%0d", burst_cnt, model_bursts()); else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [ENT_W-1:0] e;
    m_WREADY = 1'b0; s_WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin set_beat(i == 1); tick(); end
    s_WVALID = 1'b0;
    #1;
    total_cnt++; if (burst_cnt !== CNT_W'(1)) $display("FAIL mid_bcnt_pre got=%0d exp=1", burst_cnt); else pass_cnt++;
    rst = 1'b0;
    #1;
    model_q.delete();
    total_cnt++; if (empty !== 1'b1 || m_WVALID !== 1'b0)
      $display("FAIL mid_async_empty got e=%b v=%b exp 1 0", empty, m_WVALID); else pass_cnt++;
    total_cnt++; if (burst_cnt !== '0 || burst_avail !== 1'b0)
      $display("FAIL mid_async_bcnt got=%0d exp=0", burst_cnt); else pass_cnt++;
    tick();
    rst = 1'b1;
    set_beat(1'b1);
    e = cur_beat();
    s_WVALID = 1'b1;
    #1;
    total_cnt++; if (m_WVALID !== 1'b0) $display("FAIL mid_no_bypass got=%b exp=0", m_WVALID); else pass_cnt++;
    tick();
    s_WVALID = 1'b0;
    #1;
    total_cnt++; if (m_WVALID !== 1'b1 || {m_WDATA, m_WSTRB, m_WUSER, m_WLAST} !== e)
      $display("FAIL mid_first_beat got v=%b %h exp v=1 %h", m_WVALID,
               {m_WDATA, m_WSTRB, m_WUSER, m_WLAST}, e); else pass_cnt++;
    drain();
  endtask

  task automatic test_random();
    bit exp_v;
    for (int c = 0; c < 300; c++) begin
      s_WVALID = 1'(($urandom() & 3) != 0);
      m_WREADY = 1'(($urandom() & 3) != 0);
      set_beat(1'(($urandom() % 3) == 0));
      #1;
      exp_v = (model_q.size() > 0);
      total_cnt++;
      if (s_WREADY !== (model_q.size() < DEPTH) || m_WVALID !== exp_v || empty !== !exp_v ||
          full !== (model_q.size() == DEPTH) || r_enable !== (exp_v && m_WREADY))
        $display("FAIL rand_flags[%0d] got rdy=%b v=%b e=%b f=%b ren=%b occ=%0d", c, s_WREADY,
                 m_WVALID, empty, full, r_enable, model_q.size());
      else pass_cnt++;
      total_cnt++;
      if (burst_cnt !== CNT_W'(model_bursts()) || burst_avail !== (model_bursts() != 0))
        $display("FAIL rand_bcnt[%0d] got=%0d exp=%0d", c, burst_cnt, model_bursts());
      else pass_cnt++;
      if (exp_v) begin
        total_cnt++;
        if ({m_WDATA, m_WSTRB, m_WUSER, m_WLAST} !== model_q[0])
          $display("FAIL rand_head[%0d] got=%h exp=%h", c, {m_WDATA, m_WSTRB, m_WUSER, m_WLAST},
                   model_q[0]);
        else pass_cnt++;
      end
      tick();
    end
    drain();
  endtask

  initial begin
    s_WDATA = '0; s_WSTRB = '0; s_WUSER = '0; s_WLAST = 1'b0;
    s_WVALID = 1'b0; m_WREADY = 1'b0; rst = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
